// File: rtl/rxshift.sv
// ---------------------------------------------------------------------------
// rxshift - serial receive shift register (8N1, LSB first)
//
// Synchronises the asynchronous serial line, qualifies the start bit at its
// mid-point, samples eight data bits at mid-bit and checks the stop bit. A
// good frame is loaded into o_Prdata with a one-cycle o_Rx_Done pulse. A low
// stop bit gives a one-cycle o_Frame_Err pulse and leaves o_Prdata unchanged.
//
// Parameters:
//   SYNC_STAGES  flops in the i_Rx_Serial synchroniser (2 or more)
//
// Ports:
//   i_Pclk       clock, rising edge
//   i_Preset     synchronous reset, active-high
//   i_Baud[7:0]  clocks per bit; 0 and 1 are treated as 2
//   i_Enable     receiver enable, only looked at while idle
//   i_Rx_Serial  serial line, idle high, asynchronous to i_Pclk
//   o_Prdata     last good byte received
//   o_Rx_Done    1-cycle pulse when o_Prdata has been loaded
//   o_Frame_Err  1-cycle pulse when the stop bit was sampled low
//   o_Busy       high whenever the receiver is not idle
//
// Handshake: o_Rx_Done / o_Frame_Err are single-cycle strobes with no ready;
// the consumer must capture o_Prdata in the cycle o_Rx_Done is high or later
// (o_Prdata holds until the next good frame). The two strobes are exclusive.
// ---------------------------------------------------------------------------
module rxshift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Pclk,
  input  logic       i_Preset,
  input  logic [7:0] i_Baud,
  input  logic       i_Enable,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Prdata,
  output logic       o_Rx_Done,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             prdata_q, prdata_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   s_rx;
  logic [7:0]             baud_eff;
  logic [7:0]             baud_m1;
  logic [7:0]             half_m1;

  // Oldest synchroniser flop is the only one the FSM may look at.
  assign s_rx = sync_q[SYNC_STAGES-1];

  // Bit period clamped to at least 2 so the half period is never zero.
  assign baud_eff = (i_Baud < 8'd2) ? 8'd2 : i_Baud;
  assign baud_m1  = baud_eff - 8'd1;
  assign half_m1  = (baud_eff >> 1) - 8'd1;

  // Synchroniser presets to the idle level so reset never looks like a start.
  always_ff @(posedge i_Pclk) begin
    if (i_Preset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Preset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'h00;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      prdata_q <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      prdata_q <= prdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    prdata_d = prdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'h00;
        bit_d = 3'd0;
        if (i_Enable && !s_rx) begin
          state_d = S_START;
        end
      end

      // Half a bit in: a line that is high again was only a glitch.
      S_START: begin
        if (cnt_q == half_m1) begin
          cnt_d   = 8'h00;
          state_d = s_rx ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Sampling one full bit after the start mid-point keeps every
      // subsequent sample at mid-bit.
      S_DATA: begin
        if (cnt_q == baud_m1) begin
          cnt_d          = 8'h00;
          shift_d[bit_q] = s_rx;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == baud_m1) begin
          cnt_d = 8'h00;
          if (s_rx) begin
            prdata_d = shift_q;
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Pulses drop here by default; the remaining stop-bit time covers
      // this state and the return to idle before the next start edge.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_Prdata    = prdata_q;
  assign o_Rx_Done   = done_q;
  assign o_Frame_Err = err_q;
  assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rxshift.sv
// ---------------------------------------------------------------------------
// tb_rxshift - directed bench for rxshift.
// Drives 8N1 frames on the serial line from the falling clock edge, watches
// the pulse outputs on every falling edge and checks received bytes against
// an expected-byte queue.
// ---------------------------------------------------------------------------
module tb_rxshift;

  logic       clk;
  logic       preset;
  logic [7:0] baud;
  logic       en;
  logic       rx;
  logic [7:0] prdata;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int total;
  int bad;
  int done_cnt;
  int err_cnt;
  int both_cnt;
  int busy_cnt;
  int d0, e0, b0;

  logic [7:0] exp_q[$];

  rxshift #(.SYNC_STAGES(2)) dut (
    .i_Pclk      (clk),
    .i_Preset    (preset),
    .i_Baud      (baud),
    .i_Enable    (en),
    .i_Rx_Serial (rx),
    .o_Prdata    (prdata),
    .o_Rx_Done   (rx_done),
    .o_Frame_Err (frame_err),
    .o_Busy      (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!preset) begin
      if (rx_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(prdata), 32'hFFFF_FFFF);
        end else begin
          check("sb_byte", 32'(prdata), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) err_cnt++;
      if (rx_done && frame_err) both_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // Driver: called on a falling edge, leaves the line idle high on return.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int b, input bit drop_en);
    rx = 1'b0;
    repeat (b) @(negedge clk);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (b) @(negedge clk);
    end
    rx = stop;
    repeat (b) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    err_cnt  = 0;
    both_cnt = 0;
    busy_cnt = 0;
    preset   = 1'b1;
    rx       = 1'b1;
    en       = 1'b1;
    baud     = 8'd4;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_prdata", 32'(prdata), 32'h00);
    check("rst_done", 32'(rx_done), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    preset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: B=4, good frame 0xA5
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 4, 1'b0);
    repeat (10) @(negedge clk);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("t1_prdata", 32'(prdata), 32'hA5);
    check("t1_busy_idle", 32'(busy), 32'h0);

    // 2: B=8, 2-clock glitch on idle line
    baud = 8'd8;
    repeat (4) @(negedge clk);
    snap();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("t2_busy_start", 32'(busy), 32'h1);
    repeat (7) @(negedge clk);
    check("t2_busy_back", 32'(busy), 32'h0);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd0);
    check("t2_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("t2_prdata", 32'(prdata), 32'hA5);

    // 3: B=4, 0x3C with low stop bit
    baud = 8'd4;
    repeat (4) @(negedge clk);
    snap();
    send_frame(8'h3C, 1'b0, 4, 1'b0);
    repeat (30) @(negedge clk);
    check("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd0);
    check("t3_prdata", 32'(prdata), 32'hA5);
    check("t3_busy_idle", 32'(busy), 32'h0);

    // 4: B=3, 0x00 then 0xFF back-to-back
    baud = 8'd3;
    repeat (4) @(negedge clk);
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 3, 1'b0);
    send_frame(8'hFF, 1'b1, 3, 1'b0);
    repeat (8) @(negedge clk);
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("t4_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("t4_prdata", 32'(prdata), 32'hFF);

    // 4b: i_Baud=0 behaves as B=2
    baud = 8'd0;
    repeat (4) @(negedge clk);
    snap();
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 2, 1'b0);
    repeat (8) @(negedge clk);
    check("t4b_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t4b_prdata", 32'(prdata), 32'h96);

    // 5: B=6, reset during data bit 3 of 0x5A, then 0x5A received
    baud = 8'd6;
    repeat (4) @(negedge clk);
    snap();
    rx = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1) ? 1'b1 : 1'b0;
      repeat (6) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy_pre", 32'(busy), 32'h1);
    preset = 1'b1;
    @(negedge clk);
    check("t5_rst_prdata", 32'(prdata), 32'h00);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_done", 32'(rx_done), 32'h0);
    check("t5_rst_err", 32'(frame_err), 32'h0);
    preset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 6, 1'b0);
    repeat (10) @(negedge clk);
    check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t5_prdata", 32'(prdata), 32'h5A);

    // 6: disabled receiver ignores 0x81; enable dropped mid-frame still receives
    baud = 8'd4;
    en   = 1'b0;
    repeat (4) @(negedge clk);
    snap();
    send_frame(8'h81, 1'b1, 4, 1'b0);
    repeat (10) @(negedge clk);
    check("t6_dis_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    check("t6_dis_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    check("t6_dis_prdata", 32'(prdata), 32'h5A);
    en = 1'b1;
    repeat (4) @(negedge clk);
    snap();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 4, 1'b1);
    repeat (10) @(negedge clk);
    check("t6_en_drop_done", 32'(done_cnt - d0), 32'd1);
    check("t6_en_drop_prdata", 32'(prdata), 32'h81);
    check("t6_en_drop_busy", 32'(busy), 32'h0);

    // end-of-run checks
    check("both_pulses_same_cycle", 32'(both_cnt), 32'd0);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
